core_prefetch: RTL and testbench

//  Instruction prefetch queue. Producer side of the decode stage's insn input.

---
 rtl/core_prefetch_pkg.sv | 23 ++
 rtl/core_prefetch_if.sv | 31 +++
 rtl/core_prefetch_fifo.sv | 81 ++++++++
 rtl/core_prefetch.sv | 142 ++++++++++++++
 tb/tb_core_prefetch.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_prefetch_pkg.sv
// ---------------------------------------------------------------------------
// core_prefetch_pkg
//   Shared types for the instruction prefetch queue.
//   word           : 32-bit instruction word
//   ptr            : 30-bit word address
//   prefetch_entry : one queue slot {insn, pc}
//   ptr_inc        : 30-bit word address increment (wraps 3FFFFFFF -> 0)
// ---------------------------------------------------------------------------
package core_prefetch_pkg;

  typedef logic [31:0] word;
  typedef logic [29:0] ptr;

  typedef struct packed {
    word insn;
    ptr  pc;
  } prefetch_entry;

  function automatic ptr ptr_inc(input ptr p);
    return p + 30'd1;
  endfunction

endpackage

// File: rtl/core_prefetch_if.sv
// ---------------------------------------------------------------------------
// core_prefetch_if
//   Instruction bus between the prefetch queue (master) and memory (slave).
//   fetch      : read request, held until fetched
//   fetch_addr : word address, stable while fetch=1
//   fetched    : one-cycle acknowledge, fetch_data valid this cycle
//   fetch_data : returned instruction word
// ---------------------------------------------------------------------------
interface core_prefetch_if;
  import core_prefetch_pkg::*;

  logic fetch;
  ptr   fetch_addr;
  logic fetched;
  word  fetch_data;

  modport master (
    output fetch,
    output fetch_addr,
    input  fetched,
    input  fetch_data
  );

  modport slave (
    input  fetch,
    input  fetch_addr,
    output fetched,
    output fetch_data
  );

endinterface

// File: rtl/core_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// core_prefetch_fifo
//   Circular buffer of prefetch_entry, 2**ORDER entries deep.
//   clk, rst_n   : clock, async active-low reset
//   push_i       : write wr_entry_i at the tail (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : empty the buffer; overrides push and pop
//   wr_entry_i   : entry to push
//   head_o       : current head entry (content meaningless when empty)
//   empty_o      : no entries stored
//   count_o      : number of stored entries, 0..2**ORDER
// ---------------------------------------------------------------------------
module core_prefetch_fifo
  import core_prefetch_pkg::*;
#(
  parameter int ORDER = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  prefetch_entry wr_entry_i,
  output prefetch_entry head_o,
  output logic          empty_o,
  output logic [ORDER:0] count_o
);

  localparam int DEPTH = (32'sd1 << ORDER);
  localparam logic [ORDER-1:0] PTR_ONE  = ORDER'(1'b1);
  localparam logic [ORDER:0]   CNT_ONE  = (ORDER+1)'(1'b1);
  localparam logic [ORDER:0]   CNT_FULL = {1'b1, {ORDER{1'b0}}};

  prefetch_entry    mem_q [DEPTH];
  logic [ORDER-1:0] wr_q;
  logic [ORDER-1:0] rd_q;
  logic [ORDER:0]   count_q;

  logic push_ok;
  logic pop_ok;

  // Guard against over/underflow even though the FSM never requests either.
  always_comb begin
    push_ok = push_i && (count_q != CNT_FULL);
    pop_ok  = pop_i && (count_q != '0);
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wr_entry_i;
        wr_q        <= wr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_q <= rd_q + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/core_prefetch.sv
// ---------------------------------------------------------------------------
// core_prefetch
//   Instruction prefetch queue feeding the decode stage. Issues sequential
//   word fetches, buffers returned words with their PCs, and flushes /
//   refetches on a PC redirect.
//   clk, rst_n    : clock, async active-low reset
//   stall_i       : decode not accepting this cycle
//   flush_i       : redirect; queue and in-flight fetch become void
//   target_i      : word address to resume at on flush
//   insn_o        : head instruction word
//   insn_pc_o     : word address of insn_o
//   insn_valid_o  : head entry is valid
//   bus           : instruction bus, master side
// ---------------------------------------------------------------------------
module core_prefetch
  import core_prefetch_pkg::*;
#(
  parameter int ORDER    = 2,
  parameter ptr RESET_PC = 30'd0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  input  logic flush_i,
  input  ptr   target_i,
  output word  insn_o,
  output ptr   insn_pc_o,
  output logic insn_valid_o,
  core_prefetch_if.master bus
);

  localparam logic [ORDER:0] CNT_ONE  = (ORDER+1)'(1'b1);
  localparam logic [ORDER:0] CNT_FULL = {1'b1, {ORDER{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e state_q, state_d;
  ptr     addr_q, addr_d;     // request address in FETCH/DISCARD, next address in IDLE
  ptr     redir_q, redir_d;   // pending redirect target while the voided request drains

  logic           push;
  logic           pop;
  logic [ORDER:0] count;
  logic [ORDER:0] count_after;
  logic           empty;
  prefetch_entry  head;
  prefetch_entry  wr_entry;

  core_prefetch_fifo #(.ORDER(ORDER)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (flush_i),
    .wr_entry_i (wr_entry),
    .head_o     (head),
    .empty_o    (empty),
    .count_o    (count)
  );

  // Next state, address counter and queue control.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    redir_d  = redir_q;
    push     = 1'b0;
    wr_entry = '{insn: bus.fetch_data, pc: addr_q};
    pop      = !empty && !stall_i && !flush_i;
    // Occupancy after this cycle's push (if any) and pop.
    count_after = count + CNT_ONE - (pop ? CNT_ONE : '0);

    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_FETCH;
          addr_d  = target_i;
        end else if (count < CNT_FULL) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (flush_i) begin
          if (bus.fetched) begin
            // Response arrives with the redirect: drop it, no drain needed.
            state_d = S_FETCH;
            addr_d  = target_i;
          end else begin
            // Request cannot be withdrawn; hold it and drain the response.
            state_d = S_DISCARD;
            redir_d = target_i;
          end
        end else if (bus.fetched) begin
          push    = 1'b1;
          addr_d  = ptr_inc(addr_q);
          state_d = (count_after < CNT_FULL) ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (bus.fetched) begin
          state_d = S_FETCH;
          addr_d  = flush_i ? target_i : redir_q;
        end else if (flush_i) begin
          redir_d = target_i;
        end else begin
          state_d = S_DISCARD;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = RESET_PC;
      end
    endcase
  end

  // FSM and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= RESET_PC;
      redir_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      redir_q <= redir_d;
    end
  end

  assign bus.fetch      = (state_q != S_IDLE);
  assign bus.fetch_addr = addr_q;
  assign insn_valid_o   = !empty;
  assign insn_o         = head.insn;
  assign insn_pc_o      = head.pc;

endmodule

// File: tb/tb_core_prefetch.sv
module tb_core_prefetch;
  import core_prefetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  ptr   target = 30'd0;
  word  insn;
  ptr   insn_pc;
  logic insn_valid;

  logic stall2 = 1'b0;
  logic flush2 = 1'b0;
  ptr   target2 = 30'd0;
  word  insn2;
  ptr   insn_pc2;
  logic insn_valid2;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_prefetch_if bus ();
  core_prefetch_if bus2 ();

  core_prefetch #(.ORDER(2), .RESET_PC(30'd0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .flush_i      (flush),
    .target_i     (target),
    .insn_o       (insn),
    .insn_pc_o    (insn_pc),
    .insn_valid_o (insn_valid),
    .bus          (bus)
  );

  core_prefetch #(.ORDER(2), .RESET_PC(30'h3FFFFFFE)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall2),
    .flush_i      (flush2),
    .target_i     (target2),
    .insn_o       (insn2),
    .insn_pc_o    (insn_pc2),
    .insn_valid_o (insn_valid2),
    .bus          (bus2)
  );

  // Second instance: memory that acknowledges every request immediately.
  assign bus2.fetched    = bus2.fetch;
  assign bus2.fetch_data = dat(bus2.fetch_addr);

  function automatic word dat(input ptr a);
    return {2'b00, a} ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.fetched = 1'b0;
    bus.fetch_data = 32'd0;
    flush = 1'b0;
    stall = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.fetched = 1'b0;
    bus.fetch_data = 32'd0;
    @(negedge clk);

    // ---- 1: reset state, then one ack one cycle after each request
    do_reset();
    chk("rst_fetch", bus.fetch, 1'b0);
    chk("rst_addr", bus.fetch_addr, 30'd0);
    chk("rst_valid", insn_valid, 1'b0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("t1_req", bus.fetch, 1'b1);
      chk("t1_addr", bus.fetch_addr, 30'(i));
      bus.fetched = 1'b0;
      cyc();
      chk("t1_hold_valid", insn_valid, 1'b0);
      chk("t1_hold_addr", bus.fetch_addr, 30'(i));
      bus.fetched = 1'b1;
      bus.fetch_data = dat(30'(i));
      cyc();
      bus.fetched = 1'b0;
      chk("t1_valid", insn_valid, 1'b1);
      chk("t1_pc", insn_pc, 30'(i));
      chk("t1_insn", insn, dat(30'(i)));
    end

    // ---- 2: stalled decode, immediate acks fill the queue
    do_reset();
    stall = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("t2_req", bus.fetch, 1'b1);
      chk("t2_addr", bus.fetch_addr, 30'(k));
      bus.fetched = 1'b1;
      bus.fetch_data = dat(30'(k));
      cyc();
    end
    bus.fetched = 1'b0;
    chk("t2_full_fetch", bus.fetch, 1'b0);
    chk("t2_full_addr", bus.fetch_addr, 30'd4);
    cyc();
    cyc();
    chk("t2_still_idle", bus.fetch, 1'b0);
    chk("t2_head_pc", insn_pc, 30'd0);
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_pop_valid", insn_valid, 1'b1);
      chk("t2_pop_pc", insn_pc, 30'(k));
      chk("t2_pop_insn", insn, dat(30'(k)));
      cyc();
    end
    chk("t2_empty", insn_valid, 1'b0);
    chk("t2_resume", bus.fetch, 1'b1);
    chk("t2_resume_addr", bus.fetch_addr, 30'd4);

    // ---- 3: flush while request at 7 pending, ack three cycles later
    do_reset();
    cyc();
    for (int k = 0; k < 7; k++) begin
      chk("t3_addr", bus.fetch_addr, 30'(k));
      bus.fetched = 1'b1;
      bus.fetch_data = dat(30'(k));
      cyc();
    end
    bus.fetched = 1'b0;
    chk("t3_pend_addr", bus.fetch_addr, 30'd7);
    flush = 1'b1;
    target = 30'h100;
    cyc();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("t3_disc_fetch", bus.fetch, 1'b1);
      chk("t3_disc_addr", bus.fetch_addr, 30'd7);
      chk("t3_disc_valid", insn_valid, 1'b0);
      cyc();
    end
    chk("t3_disc_addr2", bus.fetch_addr, 30'd7);
    bus.fetched = 1'b1;
    bus.fetch_data = dat(30'd7);
    cyc();
    bus.fetched = 1'b0;
    chk("t3_dropped", insn_valid, 1'b0);
    chk("t3_new_req", bus.fetch, 1'b1);
    chk("t3_new_addr", bus.fetch_addr, 30'h100);
    bus.fetched = 1'b1;
    bus.fetch_data = dat(30'h100);
    cyc();
    bus.fetched = 1'b0;
    chk("t3_tgt_valid", insn_valid, 1'b1);
    chk("t3_tgt_pc", insn_pc, 30'h100);
    chk("t3_tgt_insn", insn, dat(30'h100));

    // ---- 4: flush with fetched and a pop in the same cycle
    bus.fetched = 1'b1;
    bus.fetch_data = dat(30'h101);
    flush = 1'b1;
    target = 30'h200;
    cyc();
    bus.fetched = 1'b0;
    flush = 1'b0;
    chk("t4_empty", insn_valid, 1'b0);
    chk("t4_req", bus.fetch, 1'b1);
    chk("t4_addr", bus.fetch_addr, 30'h200);
    bus.fetched = 1'b1;
    bus.fetch_data = dat(30'h200);
    cyc();
    bus.fetched = 1'b0;
    chk("t4_nodiscard_valid", insn_valid, 1'b1);
    chk("t4_nodiscard_pc", insn_pc, 30'h200);
    chk("t4_next_addr", bus.fetch_addr, 30'h201);

    // repeated flush while discarding: latest target wins
    flush = 1'b1;
    target = 30'h300;
    cyc();
    target = 30'h400;
    cyc();
    flush = 1'b0;
    chk("t4_rep_addr", bus.fetch_addr, 30'h201);
    bus.fetched = 1'b1;
    bus.fetch_data = dat(30'h201);
    cyc();
    bus.fetched = 1'b0;
    chk("t4_rep_valid", insn_valid, 1'b0);
    chk("t4_rep_target", bus.fetch_addr, 30'h400);

    // ---- 6: reset asserted mid-request
    bus.fetched = 1'b1;
    bus.fetch_data = dat(30'h400);
    cyc();
    bus.fetched = 1'b0;
    chk("t6_pre_valid", insn_valid, 1'b1);
    chk("t6_pre_fetch", bus.fetch, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_fetch", bus.fetch, 1'b0);
    chk("t6_async_valid", insn_valid, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("t6_rel_addr", bus.fetch_addr, 30'd0);
    cyc();
    chk("t6_first_req", bus.fetch, 1'b1);
    chk("t6_first_addr", bus.fetch_addr, 30'd0);

    // ---- 5: address wrap on the instance with RESET_PC = 3FFFFFFE
    do_reset();
    chk("t5_rst_fetch", bus2.fetch, 1'b0);
    chk("t5_rst_addr", bus2.fetch_addr, 30'h3FFFFFFE);
    cyc();
    chk("t5_req_addr", bus2.fetch_addr, 30'h3FFFFFFE);
    cyc();
    begin
      ptr exp_pc;
      exp_pc = 30'h3FFFFFFE;
      for (int k = 0; k < 4; k++) begin
        chk("t5_valid", insn_valid2, 1'b1);
        chk("t5_pc", insn_pc2, exp_pc);
        chk("t5_insn", insn2, dat(exp_pc));
        exp_pc = exp_pc + 30'd1;
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
